axi_aw_slave_burst_gen: RTL

//  AXI write-address slave endpoint (responder side of axi_wr_addr_channel).

---
 rtl/axi_aw_slave_burst_gen.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/axi_aw_slave_burst_gen.sv
// AXI write-address slave: queues AW requests and expands each burst into per-beat addresses.
// Define AW_WRAP_EN to build WRAP burst support; otherwise WRAP is handled as INCR.
module axi_aw_slave_burst_gen #(
  parameter int ID_MAX_WIDTH = 4,
  parameter int ADDR_WIDTH   = 32,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          awvalid,
  output logic                          awready,
  input  logic [ID_MAX_WIDTH-1:0]       awid,
  input  logic [ADDR_WIDTH-1:0]         awaddr,
  input  logic [3:0]                    awlen,
  input  logic [2:0]                    awsize,
  input  logic [1:0]                    awbrust,
  input  logic [1:0]                    awlock,
  input  logic [3:0]                    awcache,
  input  logic [2:0]                    awprot,
  input  logic [3:0]                    awqos,
  output logic                          beat_valid,
  input  logic                          beat_ready,
  output logic [ADDR_WIDTH-1:0]         beat_addr,
  output logic [ID_MAX_WIDTH-1:0]       beat_id,
  output logic [2:0]                    beat_size,
  output logic                          beat_last,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [1:0] MODE_FIXED = 2'd0;
  localparam logic [1:0] MODE_INCR  = 2'd1;
`ifdef AW_WRAP_EN
  localparam logic [1:0] MODE_WRAP  = 2'd2;
`endif

  typedef enum logic {S_IDLE, S_BURST} state_t;

  // Sideband AXI attributes are accepted but have no effect on beat generation.
  logic unused_attr;
  assign unused_attr = ^{awlock, awcache, awprot, awqos};

  logic [ID_MAX_WIDTH-1:0] q_id    [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0]   q_addr  [FIFO_DEPTH];
  logic [3:0]              q_len   [FIFO_DEPTH];
  logic [2:0]              q_size  [FIFO_DEPTH];
  logic [1:0]              q_burst [FIFO_DEPTH];

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [LVL_W-1:0] level, level_nxt;
  logic             awready_q;
  logic             push, pop, load, adv, fifo_empty;

  state_t                  state, state_nxt;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_nxt, bytes;
  logic [3:0]              cnt_q;
  logic [ID_MAX_WIDTH-1:0] id_q;
  logic [2:0]              size_q;
  logic [1:0]              mode_q, load_mode;
`ifdef AW_WRAP_EN
  logic [3:0]              len_q;
  logic [ADDR_WIDTH-1:0]   wrap_total, wrap_lower, wrap_nxt;
`endif

  assign awready    = awready_q;
  assign push       = awvalid & awready_q;
  assign fifo_empty = (level == '0);
  assign fifo_level = level;

  always_comb begin
    level_nxt = level;
    case ({push, pop})
      2'b10:   level_nxt = level + LVL_W'(1);
      2'b01:   level_nxt = level - LVL_W'(1);
      default: level_nxt = level;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      awready_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      level     <= level_nxt;
      // Registered ready: a pop while full only reopens the queue on the following cycle.
      awready_q <= (level_nxt != LVL_W'(FIFO_DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_id[wr_ptr]    <= awid;
      q_addr[wr_ptr]  <= awaddr;
      q_len[wr_ptr]   <= awlen;
      q_size[wr_ptr]  <= awsize;
      q_burst[wr_ptr] <= awbrust;
    end
  end

  always_comb begin
    load_mode = (q_burst[rd_ptr] == 2'b00) ? MODE_FIXED : MODE_INCR;
`ifdef AW_WRAP_EN
    if (q_burst[rd_ptr] == 2'b10 &&
        (q_len[rd_ptr] == 4'd1 || q_len[rd_ptr] == 4'd3 ||
         q_len[rd_ptr] == 4'd7 || q_len[rd_ptr] == 4'd15))
      load_mode = MODE_WRAP;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    load      = 1'b0;
    adv       = 1'b0;
    case (state)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          load      = 1'b1;
          state_nxt = S_BURST;
        end
      end
      S_BURST: begin
        if (beat_ready) begin
          if (cnt_q != 4'd0) begin
            adv = 1'b1;
          end else if (!fifo_empty) begin
            pop  = 1'b1;
            load = 1'b1;
          end else begin
            state_nxt = S_IDLE;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bytes    = ADDR_WIDTH'(1) << size_q;
    addr_nxt = (addr_q & ~(bytes - ADDR_WIDTH'(1))) + bytes;
    if (mode_q == MODE_FIXED) addr_nxt = addr_q;
`ifdef AW_WRAP_EN
    wrap_total = bytes * (ADDR_WIDTH'(len_q) + ADDR_WIDTH'(1));
    wrap_lower = addr_q & ~(wrap_total - ADDR_WIDTH'(1));
    wrap_nxt   = addr_q + bytes;
    if (mode_q == MODE_WRAP)
      addr_nxt = (wrap_nxt == wrap_lower + wrap_total) ? wrap_lower : wrap_nxt;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
      cnt_q  <= '0;
      id_q   <= '0;
      size_q <= '0;
      mode_q <= MODE_FIXED;
`ifdef AW_WRAP_EN
      len_q  <= '0;
`endif
    end else if (load) begin
      addr_q <= q_addr[rd_ptr];
      cnt_q  <= q_len[rd_ptr];
      id_q   <= q_id[rd_ptr];
      size_q <= q_size[rd_ptr];
      mode_q <= load_mode;
`ifdef AW_WRAP_EN
      len_q  <= q_len[rd_ptr];
`endif
    end else if (adv) begin
      addr_q <= addr_nxt;
      cnt_q  <= cnt_q - 4'd1;
    end
  end

  assign beat_valid = (state == S_BURST);
  assign beat_last  = (state == S_BURST) && (cnt_q == 4'd0);
  assign beat_addr  = addr_q;
  assign beat_id    = id_q;
  assign beat_size  = size_q;

endmodule
